// File: rtl/photonic_pkg.sv
// Shared constants, state encoding and saturating helpers for the photonic order receiver.
package photonic_pkg;

    localparam int         DATA_W_DEF      = 128;
    localparam logic [7:0] PREAMBLE_DEF    = 8'hD5;
    localparam int         SYNC_STAGES_DEF = 2;
    localparam int         LAT_W           = 32;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'b00,
        ST_PAYLOAD = 2'b01,
        ST_DONE    = 2'b10,
        ST_BAD     = 2'b11
    } rx_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] i_v);
        return (i_v == 16'hFFFF) ? i_v : i_v + 16'd1;
    endfunction

    function automatic logic [LAT_W-1:0] sat_inc_lat(input logic [LAT_W-1:0] i_v);
        return (i_v == {LAT_W{1'b1}}) ? i_v : i_v + {{(LAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/photonic_order_receiver_sync.sv
// Flop chain that brings the raw optical pulse line into the system clock domain.
module photonic_pulse_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/photonic_order_receiver.sv
// Hunts for the preamble on the synchronised pulse line, deserialises the payload LSB first
// and holds the resulting order word on a valid/ready output with latency and drop statistics.
module photonic_order_receiver
    import photonic_pkg::*;
#(
    parameter int         DATA_W      = DATA_W_DEF,
    parameter logic [7:0] PREAMBLE    = PREAMBLE_DEF,
    parameter int         SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk_156mhz,
    input  logic              reset,
    input  logic              photonic_pulse_in,
    output logic [DATA_W-1:0] order_data,
    output logic              order_valid,
    input  logic              order_ready,
    output logic [LAT_W-1:0]  frame_latency,
    output logic [15:0]       frame_count,
    output logic [15:0]       overflow_count,
    output logic              rx_busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a word transfers on every rising edge where order_valid and order_ready are
    // both high; while order_valid is high and not accepted, order_data is held unchanged.

    logic              w_bit;
    rx_state_t         r_state;
    rx_state_t         w_next_state;
    logic [6:0]        r_hunt_hist;
    logic [7:0]        w_hunt_next;
    logic [DATA_W-1:0] r_shift;
    logic [7:0]        r_bit_cnt;
    logic [LAT_W-1:0]  r_rx_lat;
    logic [LAT_W-1:0]  r_hold_lat;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [LAT_W-1:0]  r_frame_lat;
    logic [15:0]       r_frame_cnt;
    logic [15:0]       r_over_cnt;
    logic              w_handshake;
    logic              w_load;
    logic              w_drop;

    photonic_pulse_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (clk_156mhz),
        .i_rst (reset),
        .i_d   (photonic_pulse_in),
        .o_q   (w_bit)
    );

    // The hunt register's newest value is the 7 held bits plus the bit arriving now, so the
    // match is taken on that value and PAYLOAD starts with the very next sampled bit.
    always_comb begin
        w_next_state = r_state;
        w_hunt_next  = {r_hunt_hist, w_bit};
        w_handshake  = r_valid && order_ready;
        w_load       = (r_state == ST_DONE) && (!r_valid || w_handshake);
        w_drop       = (r_state == ST_DONE) && !w_load;
        case (r_state)
            ST_HUNT:    if (w_hunt_next == PREAMBLE) w_next_state = ST_PAYLOAD;
            ST_PAYLOAD: if (r_bit_cnt == 8'(DATA_W - 1)) w_next_state = ST_DONE;
            ST_DONE:    w_next_state = ST_HUNT;
            default:    w_next_state = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk_156mhz or posedge reset) begin
        if (reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_156mhz or posedge reset) begin
        if (reset) begin
            r_hunt_hist <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_rx_lat    <= '0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    r_hunt_hist <= w_hunt_next[6:0];
                    r_bit_cnt   <= '0;
                    r_rx_lat    <= '0;
                end
                ST_PAYLOAD: begin
                    r_shift   <= {w_bit, r_shift[DATA_W-1:1]};
                    r_bit_cnt <= r_bit_cnt + 8'd1;
                    r_rx_lat  <= sat_inc_lat(r_rx_lat);
                end
                default: begin
                    // Payload tail bits must not be able to complete a preamble.
                    r_hunt_hist <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_156mhz or posedge reset) begin
        if (reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_hold_lat  <= '0;
            r_frame_lat <= '0;
            r_frame_cnt <= '0;
            r_over_cnt  <= '0;
        end else begin
            if (w_load) begin
                r_data     <= r_shift;
                r_valid    <= 1'b1;
                r_hold_lat <= sat_inc_lat(r_rx_lat);
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end else if (r_valid) begin
                r_hold_lat <= sat_inc_lat(r_hold_lat);
            end
            if (w_handshake) begin
                r_frame_lat <= r_hold_lat;
                r_frame_cnt <= sat_inc16(r_frame_cnt);
            end
            if (w_drop) begin
                r_over_cnt <= sat_inc16(r_over_cnt);
            end
        end
    end

    assign order_data     = r_data;
    assign order_valid    = r_valid;
    assign frame_latency  = r_frame_lat;
    assign frame_count    = r_frame_cnt;
    assign overflow_count = r_over_cnt;
    assign rx_busy        = (r_state == ST_PAYLOAD) || (r_state == ST_DONE);
    assign dbg_state      = r_state;

endmodule

// File: doc/photonic_order_receiver.md
Name: photonic_order_receiver

Overview:
- Receive-side counterpart of the photonic order transmitter.
- Samples the incoming 1550 nm pulse line on the 156.25 MHz system clock and hunts for an 8-bit preamble.
- Deserialises the following 128 payload bits, LSB first, into an order word.
- Presents the word on a valid/ready interface to the downstream order decoder, and reports handshake latency plus frame and overflow statistics.

Parameters:
- DATA_W, 128: payload width in bits; the payload counter is 8 bits wide.
- PREAMBLE, 8'hD5: frame marker, PREAMBLE[7] is received first. 8'h00 is illegal because the idle line is low.
- SYNC_STAGES, 2: synchroniser depth on photonic_pulse_in; legal values are 2 and 3.

Ports:
- clk_156mhz  in  1  system clock, 156.25 MHz
- reset  in  1  asynchronous reset, active-high
- photonic_pulse_in  in  1  raw pulse line from the optical front end
- order_data  out  DATA_W  received order word
- order_valid  out  1  order_data is valid
- order_ready  in  1  downstream accepts order_data
- frame_latency  out  32  cycles from first payload bit to handshake
- frame_count  out  16  frames delivered by handshake, saturating
- overflow_count  out  16  frames dropped while the output was full, saturating
- rx_busy  out  1  high while in PAYLOAD or DONE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - While reset is high, all outputs are 0, the state is HUNT, and the synchroniser, hunt shift register and all counters are 0.
  - Reset asserted mid-frame discards the partial frame and any held word.
- Synchroniser: photonic_pulse_in passes through SYNC_STAGES flops. The sampled bit is the last stage output.
- HUNT:
  - hunt_sr <= {hunt_sr[6:0], bit} every cycle.
  - When hunt_sr == PREAMBLE, the next cycle is PAYLOAD with bit_cnt=0 and rx_lat=0.
- PAYLOAD:
  - shift_reg <= {bit, shift_reg[DATA_W-1:1]}, so the first payload bit lands at [0].
  - bit_cnt and rx_lat increment every cycle.
  - At bit_cnt == DATA_W-1, capture the final bit and go to DONE.
- DONE (one cycle):
  - If the output register is free, or is freed this cycle by order_valid && order_ready: load order_data <= shift_reg, set order_valid=1 and hold_lat <= rx_lat+1.
  - Otherwise drop the frame and increment overflow_count.
  - In both cases clear hunt_sr to 0 so payload tail bits cannot fake a preamble, then return to HUNT.
- Output hold:
  - While order_valid is high, order_data is stable and hold_lat increments every cycle.
  - On the order_valid && order_ready cycle: frame_latency <= hold_lat, frame_count increments, and order_valid falls on the next edge unless DONE reloads it in that same cycle.
  - The minimum frame_latency is 129: 128 payload cycles plus the DONE cycle, with ready held high.
- Saturation: frame_count and overflow_count saturate at 16'hFFFF. hold_lat and rx_lat saturate at 32'hFFFFFFFF.
- Framing: a preamble appearing during PAYLOAD is treated as data. There is no resynchronisation until DONE.
- Timing: order_valid first asserts DATA_W+SYNC_STAGES+2 edges after the last preamble bit is driven on the pin.

Decomposition:
- Shared package photonic_pkg:
  - DATA_W, PREAMBLE and SYNC_STAGES defaults
  - state encoding: HUNT=2'b00, PAYLOAD=2'b01, DONE=2'b10, with 2'b11 recovering to HUNT
  - latency counter width constant of 32
- One sub-module, photonic_pulse_sync: the parameterised synchroniser flop chain with asynchronous active-high clear.

Test Plan:
- Basic frame: drive 8'hD5, then payload 128'h0123456789ABCDEF_FEDCBA9876543210 LSB first, with ready=1.
  - order_data matches the payload and order_valid lasts one cycle.
  - frame_latency=129 and frame_count=1.
- Backpressure:
  - Ready is low for 50 cycles after valid, then high: order_data is stable throughout and frame_latency=179.
  - A second complete frame arrives while the first is still held: the second frame is dropped, overflow_count=1 and the held data is unchanged.
- Simultaneous free and load: ready rises in exactly the DONE cycle of the second frame.
  - frame 1 handshakes, frame 2 loads, order_valid stays high, overflow_count=0 and frame_count=1.
- False and partial preamble:
  - Drive 8'hD4, then idle: no frame starts.
  - Drive a payload containing 8'hD5 at bits 40..47: it is received as data with no early termination.
- Reset mid-frame: assert reset at payload bit 60.
  - All outputs return to 0.
  - A subsequent clean frame 128'hFFFF...FFFF is received correctly with frame_count=1.
